// File: rtl/level_meter_pkg.sv
// Shared defaults for the level meter slice: sample width, window size, clip threshold.
`timescale 1ns/1ps
package level_meter_pkg;
  localparam int          DSZ_DEF  = 16;
  localparam int          WIN_DEF  = 10;
  localparam int unsigned CLIP_DEF = 32767;
endpackage

// File: rtl/level_meter_if.sv
// Sample-in / result-out bundle between the DC-block stage and the level meter.
`timescale 1ns/1ps
interface level_meter_if import level_meter_pkg::*; #(
  parameter int dsz = DSZ_DEF,
  parameter int win = WIN_DEF
);
  logic signed [dsz-1:0] in;
  logic                  ena;
  logic                  clr;
  logic        [dsz-1:0] peak;
  logic        [dsz-1:0] mean;
  logic        [win:0]   clips;
  logic                  valid;

  modport master (
    output in, ena, clr,
    input  peak, mean, clips, valid
  );

  modport slave (
    input  in, ena, clr,
    output peak, mean, clips, valid
  );
endinterface

// File: rtl/level_meter_abs_sat.sv
// Combinational |x| for signed samples; the most-negative value saturates to the
// largest positive magnitude so the result always fits in dsz-1 bits.
`timescale 1ns/1ps
module level_meter_abs_sat import level_meter_pkg::*; #(
  parameter int dsz = DSZ_DEF
) (
  input  logic signed [dsz-1:0] x,
  output logic        [dsz-2:0] mag
);

  function automatic logic [dsz-2:0] sat_abs(input logic signed [dsz-1:0] v);
    logic signed [dsz-1:0] n;
    n = -v;
    if (v[dsz-1] == 1'b0)
      return v[dsz-2:0];
    else if (n[dsz-1])
      return '1;  // only -2^(dsz-1) negates back to a negative value
    else
      return n[dsz-2:0];
  endfunction

  assign mag = sat_abs(x);

endmodule

// File: rtl/level_meter.sv
// Windowed level meter: peak, mean and clip count of |in| over 2^win accepted
// samples, published with a one-cycle valid pulse at the end of each window.
`timescale 1ns/1ps
module level_meter import level_meter_pkg::*; #(
  parameter int          dsz      = DSZ_DEF,
  parameter int          win      = WIN_DEF,
  parameter int unsigned clip_lvl = CLIP_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  level_meter_if.slave lm
);

  localparam int              MW       = dsz - 1;
  localparam int              SW       = dsz - 1 + win;
  localparam int              CW       = win + 1;
  localparam logic [MW-1:0]   CLIP_T   = MW'(clip_lvl);
  localparam logic [win-1:0]  CNT_LAST = '1;
  localparam logic [win-1:0]  CNT_ONE  = win'(1);

  logic [MW-1:0]  mag_p0;
  logic           clip_p0;
  logic           take_p0;

  logic [MW-1:0]  mag_p1;
  logic           clip_p1;
  logic           vld_p1;

  logic [MW-1:0]  pk_acc;
  logic [SW-1:0]  sum_acc;
  logic [CW-1:0]  clip_acc;
  logic [win-1:0] cnt;

  logic [MW-1:0]  pk_nxt;
  logic [SW-1:0]  sum_nxt;
  logic [CW-1:0]  clip_nxt;
  logic           last_p1;

  logic [dsz-1:0] peak_p2;
  logic [dsz-1:0] mean_p2;
  logic [CW-1:0]  clips_p2;
  logic           vld_p2;

  // Stage 0 -> 1: magnitude and clip flag of the incoming sample
  level_meter_abs_sat #(.dsz(dsz)) u_abs_sat (
    .x   (lm.in),
    .mag (mag_p0)
  );

  assign clip_p0 = (mag_p0 >= CLIP_T);
  assign take_p0 = lm.ena && !lm.clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1  <= 1'b0;
      mag_p1  <= '0;
      clip_p1 <= 1'b0;
    end else begin
      vld_p1 <= take_p0;
      if (take_p0) begin
        mag_p1  <= mag_p0;
        clip_p1 <= clip_p0;
      end
    end
  end

  // Stage 1 -> 2: window accumulation; the closing sample is folded in directly
  // so the accumulators can restart on the same edge the results are published.
  assign pk_nxt   = (mag_p1 > pk_acc) ? mag_p1 : pk_acc;
  assign sum_nxt  = sum_acc + SW'(mag_p1);
  assign clip_nxt = clip_acc + CW'(clip_p1);
  assign last_p1  = vld_p1 && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pk_acc   <= '0;
      sum_acc  <= '0;
      clip_acc <= '0;
      cnt      <= '0;
      peak_p2  <= '0;
      mean_p2  <= '0;
      clips_p2 <= '0;
      vld_p2   <= 1'b0;
    end else if (lm.clr) begin
      pk_acc   <= '0;
      sum_acc  <= '0;
      clip_acc <= '0;
      cnt      <= '0;
      vld_p2   <= 1'b0;
    end else if (last_p1) begin
      pk_acc   <= '0;
      sum_acc  <= '0;
      clip_acc <= '0;
      cnt      <= '0;
      peak_p2  <= {1'b0, pk_nxt};
      mean_p2  <= {1'b0, sum_nxt[SW-1:win]};
      clips_p2 <= clip_nxt;
      vld_p2   <= 1'b1;
    end else begin
      vld_p2 <= 1'b0;
      if (vld_p1) begin
        pk_acc   <= pk_nxt;
        sum_acc  <= sum_nxt;
        clip_acc <= clip_nxt;
        cnt      <= cnt + CNT_ONE;
      end
    end
  end

  assign lm.peak  = peak_p2;
  assign lm.mean  = mean_p2;
  assign lm.clips = clips_p2;
  assign lm.valid = vld_p2;

endmodule

// File: tb/tb_level_meter.sv
// Scoreboard bench for level_meter at win=2: a window model predicts each result,
// a negedge monitor checks pulses, latency and that outputs hold in between.
`timescale 1ns/1ps
module tb_level_meter;
  localparam int DSZ  = 16;
  localparam int WIN  = 2;
  localparam int WLEN = 4;

  typedef struct {
    int peak;
    int mean;
    int clips;
    int due;
  } res_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  level_meter_if #(.dsz(DSZ), .win(WIN)) lm ();

  level_meter #(.dsz(DSZ), .win(WIN), .clip_lvl(32767)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .lm      (lm)
  );

  res_t exp_q[$];
  res_t held;
  int   win_q[$];
  bit   pend_v = 0;
  int   pend_m = 0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int mag_of(input int x);
    if (x <= -32768) return 32767;
    return (x < 0) ? -x : x;
  endfunction

  // A sample counts once the cycle after it was accepted passes without clr.
  task automatic commit(input int m);
    res_t r;
    int sum;
    win_q.push_back(m);
    if (win_q.size() == WLEN) begin
      r.peak = 0; r.clips = 0; sum = 0;
      foreach (win_q[i]) begin
        if (win_q[i] > r.peak) r.peak = win_q[i];
        if (win_q[i] >= 32767) r.clips++;
        sum += win_q[i];
      end
      r.mean = sum / WLEN;
      r.due  = cyc + 1;
      exp_q.push_back(r);
      win_q.delete();
    end
  endtask

  task automatic drive(input bit e, input int x, input bit c);
    @(posedge clk);
    #1;
    if (c) begin
      win_q.delete();
      pend_v = 0;
    end else begin
      if (pend_v) commit(pend_m);
      pend_v = e;
      pend_m = mag_of(x);
    end
    lm.ena = e;
    lm.in  = 16'(x);
    lm.clr = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0);
  endtask

  task automatic win4(input int a, input int b, input int c, input int d);
    drive(1'b1, a, 1'b0);
    drive(1'b1, b, 1'b0);
    drive(1'b1, c, 1'b0);
    drive(1'b1, d, 1'b0);
  endtask

  task automatic chk_out(input string tag, input int pk, input int mn, input int cl);
    chk({tag, "_peak"},  int'(lm.peak),  pk);
    chk({tag, "_mean"},  int'(lm.mean),  mn);
    chk({tag, "_clips"}, int'(lm.clips), cl);
  endtask

  always @(negedge clk) begin
    res_t r;
    if (reset_n) begin
      if (lm.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          r = exp_q.pop_front();
          chk("latency", cyc, r.due);
          chk("res_peak",  int'(lm.peak),  r.peak);
          chk("res_mean",  int'(lm.mean),  r.mean);
          chk("res_clips", int'(lm.clips), r.clips);
          held = r;
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          chk("missed_pulse", cyc, exp_q[0].due + 1000);
          void'(exp_q.pop_front());
        end
        chk("hold_peak",  int'(lm.peak),  held.peak);
        chk("hold_mean",  int'(lm.mean),  held.mean);
        chk("hold_clips", int'(lm.clips), held.clips);
      end
    end
  end

  initial begin
    int x;
    bit e, c;
    lm.ena = 1'b0;
    lm.in  = '0;
    lm.clr = 1'b0;
    held   = '{0, 0, 0, 0};

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0);
    chk("reset_valid", int'(lm.valid), 0);
    @(posedge clk);
    #3 reset_n = 1'b1;

    win4(100, -200, 50, -8);
    idle(4);
    chk_out("t1", 200, 89, 0);

    drive(1'b1, -32768, 1'b0); idle(1);
    drive(1'b1, 32767, 1'b0);  idle(1);
    drive(1'b1, 0, 1'b0);      idle(1);
    drive(1'b1, 1, 1'b0);
    idle(4);
    chk_out("t2", 32767, 16383, 2);

    win4(1, 1, 1, 1);
    win4(4, 4, 4, 4);
    idle(4);
    chk_out("t3", 4, 4, 0);

    drive(1'b1, 1000, 1'b0);
    drive(1'b1, 1000, 1'b0);
    drive(1'b0, 0, 1'b1);
    win4(10, 10, 10, 10);
    idle(4);
    chk_out("t4", 10, 10, 0);

    drive(1'b1, 5, 1'b0);
    drive(1'b1, 5, 1'b0);
    drive(1'b1, 5, 1'b0);
    drive(1'b1, 9, 1'b1);
    idle(3);
    win4(7, 7, 7, 7);
    idle(4);
    chk_out("t5", 7, 7, 0);

    for (int i = 0; i < 600; i++) begin
      e = ($urandom_range(0, 99) < 70);
      c = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 5))
        0:       x = -32768;
        1:       x = 32767;
        2:       x = -32767;
        3:       x = 32766;
        default: x = int'($urandom_range(0, 65535)) - 32768;
      endcase
      drive(e, x, c);
    end
    idle(4);

    win4(300, -300, 300, -300);
    idle(4);
    chk_out("pre_rst", 300, 300, 0);
    drive(1'b1, 50, 1'b0);
    drive(1'b1, 50, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    lm.ena  = 1'b0;
    win_q.delete();
    exp_q.delete();
    pend_v = 0;
    held   = '{0, 0, 0, 0};
    #1;
    chk_out("async_rst", 0, 0, 0);
    chk("async_rst_valid", int'(lm.valid), 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;

    drive(1'b1, 20, 1'b0);
    drive(1'b1, 20, 1'b0);
    drive(1'b1, 20, 1'b0);
    idle(4);
    chk_out("post_rst_partial", 0, 0, 0);
    drive(1'b1, 20, 1'b0);
    idle(4);
    chk_out("post_rst", 20, 20, 0);

    idle(4);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
